seg_decode_rx: RTL and testbench

Receive-side counterpart of the seven-segment symbol encoder. It samples an 8-bit active-low segment bus, for example a display bus looped back or tapped from another board. It waits until the pattern has been stable for a programmable number of cycles, then decodes it back to the 3-bit symbol code. Each newly settled symbol is delivered over a valid/ready interface. The block sits between the display tap and the floor-tracking/checker logic, and also counts malformed patterns.

---
 rtl/seg_decode_rx_pkg.sv | 43 ++++
 rtl/seg_decode_rx_if.sv | 9 +
 rtl/seg_decode_rx_sync.sv | 27 ++
 rtl/seg_decode_rx.sv | 144 ++++++++++++++
 tb/tb_seg_decode_rx.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_decode_rx_pkg.sv
// Shared seven-segment constants, FSM state type and pattern decode lookup.
// Used by both the segment encoder and the receive-side decoder.
package seg_pkg;

    localparam logic [7:0] SEG_F     = 8'b10001110;
    localparam logic [7:0] SEG_1     = 8'b11111001;
    localparam logic [7:0] SEG_2     = 8'b10100100;
    localparam logic [7:0] SEG_3     = 8'b10110000;
    localparam logic [7:0] SEG_H     = 8'b10001001;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [2:0] CODE_F = 3'b000;
    localparam logic [2:0] CODE_1 = 3'b001;
    localparam logic [2:0] CODE_2 = 3'b010;
    localparam logic [2:0] CODE_3 = 3'b011;
    localparam logic [2:0] CODE_H = 3'b111;

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} seg_state_e;

    typedef enum logic [1:0] {SYM_LEGAL, SYM_BLANK, SYM_INVALID} seg_kind_e;

    typedef struct packed {
        seg_kind_e  kind;
        logic [2:0] code;
    } seg_dec_t;

    function automatic seg_dec_t seg_decode(input logic [7:0] pat);
        seg_dec_t r;
        r.kind = SYM_LEGAL;
        r.code = CODE_F;
        case (pat)
            SEG_F:     r.code = CODE_F;
            SEG_1:     r.code = CODE_1;
            SEG_2:     r.code = CODE_2;
            SEG_3:     r.code = CODE_3;
            SEG_H:     r.code = CODE_H;
            SEG_BLANK: r.kind = SYM_BLANK;
            default:   r.kind = SYM_INVALID;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_decode_rx_if.sv
// Valid/ready symbol stream from the segment decoder to its consumer.
interface seg_decode_rx_if;
    logic [2:0] data;
    logic       data_valid;
    logic       data_ready;

    modport master (output data, output data_valid, input data_ready);
    modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/seg_decode_rx_sync.sv
// Two-flop synchronizer for a bus of independent bits; resets to all ones
// so an idle (blank) active-low display reads as blank through reset.
module seg_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/seg_decode_rx.sv
// Seven-segment receive decoder: synchronize, debounce to a stable pattern,
// decode to a symbol code and hand each newly settled symbol to a consumer.
module seg_decode_rx
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            display,
    seg_decode_rx_if.master       bus,
    output logic                  err,
    output logic [7:0]            err_cnt,
    output logic                  ovf
);

    localparam int unsigned    CntW    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

    logic [7:0]      w_samp;
    seg_state_e      r_state, w_state_nx;
    logic [7:0]      r_cand, w_cand_nx;
    logic [CntW-1:0] r_cnt, w_cnt_nx;
    logic [7:0]      r_locked, w_locked_nx;
    logic            w_accept;
    logic [7:0]      w_acc_pat;
    seg_dec_t        w_dec;
    logic            w_new;
    logic            w_load;
    logic            w_bad;
    logic            w_xfer;

    logic [2:0]      r_data;
    logic            r_valid;
    logic            r_err;
    logic [7:0]      r_err_cnt;
    logic            r_ovf;

    seg_sync #(
        .WIDTH (8)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (display),
        .o_q   (w_samp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cand   <= SEG_BLANK;
            r_cnt    <= '0;
            r_locked <= SEG_BLANK;
        end else begin
            r_state  <= w_state_nx;
            r_cand   <= w_cand_nx;
            r_cnt    <= w_cnt_nx;
            r_locked <= w_locked_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cand_nx  = r_cand;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        w_acc_pat  = r_cand;
        unique case (r_state)
            IDLE: begin
                w_cand_nx = w_samp;
                w_cnt_nx  = CntOne;
                // A single-cycle stability window accepts the very first sample.
                if (STABLE_CYCLES == 1) begin
                    w_accept   = 1'b1;
                    w_acc_pat  = w_samp;
                    w_state_nx = LOCKED;
                end else begin
                    w_state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (w_samp != r_cand) begin
                    w_cand_nx = w_samp;
                    w_cnt_nx  = CntOne;
                end else if (r_cnt < CntLast) begin
                    w_cnt_nx = r_cnt + CntOne;
                end else begin
                    w_accept   = 1'b1;
                    w_state_nx = LOCKED;
                end
            end
            LOCKED: begin
                if (w_samp != r_locked) begin
                    w_cand_nx  = w_samp;
                    w_cnt_nx   = CntOne;
                    w_state_nx = SETTLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Only a change of the locked pattern produces output or an error.
    assign w_dec       = seg_decode(w_acc_pat);
    assign w_new       = w_accept && (w_acc_pat != r_locked);
    assign w_load      = w_new && (w_dec.kind == SYM_LEGAL);
    assign w_bad       = w_new && (w_dec.kind == SYM_INVALID);
    assign w_locked_nx = w_accept ? w_acc_pat : r_locked;
    assign w_xfer      = r_valid && bus.data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_err <= w_bad;
            if (w_bad && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_load) begin
                // Full and not draining: keep the held symbol, drop the new one.
                if (r_valid && !bus.data_ready) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_data  <= w_dec.code;
                    r_valid <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data       = r_data;
    assign bus.data_valid = r_valid;
    assign err            = r_err;
    assign err_cnt        = r_err_cnt;
    assign ovf            = r_ovf;

endmodule

// File: tb/tb_seg_decode_rx.sv
// Directed bench for seg_decode_rx: decode table, debounce, error count,
// overflow, load-with-transfer and asynchronous reset behaviour.
module tb_seg_decode_rx;
    import seg_pkg::*;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] display = SEG_BLANK;
    logic       err;
    logic [7:0] err_cnt;
    logic       ovf;

    seg_decode_rx_if bus ();

    seg_decode_rx #(
        .STABLE_CYCLES (S)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .display (display),
        .bus     (bus),
        .err     (err),
        .err_cnt (err_cnt),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_xfer = 0;
    int         n_errp = 0;
    logic [2:0] last_data = 3'b000;

    // Observe completed transfers and err pulses mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.data_valid && bus.data_ready) begin
                n_xfer++;
                last_data = bus.data;
            end
            if (err) n_errp++;
        end
    end

    typedef struct {
        logic [7:0] pat;
        int         exp_xfer;
        logic [2:0] exp_code;
        int         exp_err;
        string      name;
    } vec_t;

    vec_t vecs[10];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Release reset and report the first edge with valid high and how many
    // post-edge samples saw it high.
    task automatic release_and_watch(output int e_first, output int n_hi);
        e_first = 0;
        n_hi    = 0;
        rst_n   = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step(1);
            if (bus.data_valid) begin
                if (e_first == 0) e_first = e;
                n_hi++;
            end
        end
    endtask

    initial begin
        int e_first;
        int n_hi;
        int x0;
        int e0;
        int exp_errc;

        vecs[0] = '{SEG_F,     1, CODE_F, 0, "F"};
        vecs[1] = '{SEG_1,     1, CODE_1, 0, "one"};
        vecs[2] = '{SEG_2,     1, CODE_2, 0, "two"};
        vecs[3] = '{SEG_3,     1, CODE_3, 0, "three"};
        vecs[4] = '{SEG_H,     1, CODE_H, 0, "H"};
        vecs[5] = '{8'h00,     0, 3'b000, 1, "all_on"};
        vecs[6] = '{8'h7F,     0, 3'b000, 1, "dp_only"};
        vecs[7] = '{8'h0E,     0, 3'b000, 1, "F_with_dp"};
        vecs[8] = '{8'hFE,     0, 3'b000, 1, "seg_a_only"};
        vecs[9] = '{SEG_BLANK, 0, 3'b000, 0, "blank"};

        // Reset values
        display        = SEG_2;
        bus.data_ready = 1'b1;
        step(2);
        check("rst_data", 32'(bus.data), 0);
        check("rst_valid", 32'(bus.data_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_ovf", 32'(ovf), 0);

        // Basic decode latency from reset release
        release_and_watch(e_first, n_hi);
        check("basic_first_edge", 32'(e_first), S + 2);
        check("basic_valid_cycles", 32'(n_hi), 1);
        check("basic_data", 32'(last_data), 32'(CODE_2));
        check("basic_no_err", 32'(n_errp), 0);

        // Short glitch then back to the locked symbol: nothing emitted
        x0      = n_xfer;
        display = SEG_3;
        step(2);
        display = SEG_2;
        step(20);
        check("glitch_no_output", 32'(n_xfer - x0), 0);
        display = SEG_BLANK;
        step(10);
        display = SEG_2;
        step(12);
        check("reemit_after_blank", 32'(n_xfer - x0), 1);
        check("reemit_data", 32'(last_data), 32'(CODE_2));

        // Decode table, each pattern entered from blank
        exp_errc = 0;
        for (int i = 0; i < 10; i++) begin
            display = SEG_BLANK;
            step(10);
            x0      = n_xfer;
            e0      = n_errp;
            display = vecs[i].pat;
            step(12);
            check({"tbl_xfer_", vecs[i].name}, 32'(n_xfer - x0), 32'(vecs[i].exp_xfer));
            if (vecs[i].exp_xfer > 0)
                check({"tbl_code_", vecs[i].name}, 32'(last_data), 32'(vecs[i].exp_code));
            check({"tbl_err_", vecs[i].name}, 32'(n_errp - e0), 32'(vecs[i].exp_err));
            exp_errc += vecs[i].exp_err;
            check({"tbl_err_cnt_", vecs[i].name}, 32'(err_cnt), 32'(exp_errc));
        end

        // Error counter saturation
        e0 = n_errp;
        for (int i = 0; i < 300; i++) begin
            display = (i % 2 == 0) ? 8'h55 : 8'h00;
            step(8);
            display = SEG_BLANK;
            step(8);
        end
        check("sat_err_pulses", 32'(n_errp - e0), 300);
        check("sat_err_cnt", 32'(err_cnt), 255);

        // Overflow: second symbol arrives while the first is held
        check("ovf_clear_before", 32'(ovf), 0);
        bus.data_ready = 1'b0;
        display = SEG_F;
        step(8);
        display = SEG_BLANK;
        step(8);
        display = SEG_H;
        step(8);
        check("ovf_valid_held", 32'(bus.data_valid), 1);
        check("ovf_data_kept", 32'(bus.data), 32'(CODE_F));
        check("ovf_set", 32'(ovf), 1);
        x0 = n_xfer;
        bus.data_ready = 1'b1;
        step(1);
        bus.data_ready = 1'b0;
        check("ovf_drain_count", 32'(n_xfer - x0), 1);
        check("ovf_drain_data", 32'(last_data), 32'(CODE_F));
        check("ovf_drain_valid", 32'(bus.data_valid), 0);
        check("ovf_sticky", 32'(ovf), 1);

        // Asynchronous reset clears sticky and saturated state immediately
        rst_n = 1'b0;
        #1;
        check("arst_ovf", 32'(ovf), 0);
        check("arst_err_cnt", 32'(err_cnt), 0);
        step(2);

        // Load on the same edge as a transfer
        display = SEG_1;
        rst_n   = 1'b1;
        step(8);
        check("sim_one_held", 32'(bus.data), 32'(CODE_1));
        display = SEG_BLANK;
        step(10);
        x0      = n_xfer;
        display = SEG_H;
        step(S + 1);
        check("sim_pre_valid", 32'(bus.data_valid), 1);
        check("sim_pre_data", 32'(bus.data), 32'(CODE_1));
        bus.data_ready = 1'b1;
        step(1);
        check("sim_valid_stays", 32'(bus.data_valid), 1);
        check("sim_data_H", 32'(bus.data), 32'(CODE_H));
        check("sim_no_ovf", 32'(ovf), 0);
        step(1);
        check("sim_xfers", 32'(n_xfer - x0), 2);
        check("sim_last_H", 32'(last_data), 32'(CODE_H));
        check("sim_drained", 32'(bus.data_valid), 0);

        // Reset mid-SETTLE with a symbol held
        bus.data_ready = 1'b0;
        display = SEG_2;
        step(8);
        check("mid_valid_before", 32'(bus.data_valid), 1);
        display = SEG_3;
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.data_valid), 0);
        check("mid_rst_data", 32'(bus.data), 0);
        check("mid_rst_err", 32'(err), 0);
        step(2);
        bus.data_ready = 1'b1;
        x0 = n_xfer;
        release_and_watch(e_first, n_hi);
        check("mid_first_edge", 32'(e_first), S + 2);
        check("mid_valid_cycles", 32'(n_hi), 1);
        check("mid_xfers", 32'(n_xfer - x0), 1);
        check("mid_data", 32'(last_data), 32'(CODE_3));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_fail);
        $finish;
    end

endmodule
